// File: rtl/fir2d_pkg.sv
// Shared constants and helpers for the 2D FIR tap-accumulate stage.
package fir2d_pkg;

  localparam int PIX_W     = 8;
  localparam int PROD_W    = 16;
  localparam int TAP_IDX_W = 4;
  localparam int DEF_TAPS  = 9;
  localparam int DEF_SHIFT = 8;

  // Smallest r with 2**r >= v; used to size the accumulator at elaboration.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir2d_round_sat.sv
// Round-half-up, right-shift and saturate a window sum down to one pixel.
module fir2d_round_sat
  import fir2d_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [ACC_W-1:0] sum,
  output logic [PIX_W-1:0] pix
);

  // One extra bit so the rounding add can never wrap.
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] PMAX = (ACC_W+1)'((1 << PIX_W) - 1);

  logic [ACC_W:0] rnd;
  logic [ACC_W:0] r;

  assign rnd = {1'b0, sum} + HALF;
  assign r   = rnd >> SHIFT;
  assign pix = (r > PMAX) ? {PIX_W{1'b1}} : r[PIX_W-1:0];

endmodule

// File: rtl/fir2d_tap_accum.sv
// Accumulates TAPS partial products per window and presents the window sum
// and its rounded, saturated pixel through a valid/ready output register.
module fir2d_tap_accum
  import fir2d_pkg::*;
#(
  parameter int TAPS  = DEF_TAPS,
  parameter int SHIFT = DEF_SHIFT,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PROD_W-1:0]    ax,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clr,
  output logic [TAP_IDX_W-1:0] tap_idx,
  output logic [ACC_W-1:0]     sum_out,
  output logic [PIX_W-1:0]     pix_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  if ((TAPS < 2) || (TAPS > 16) || (SHIFT < 1) || (SHIFT > 12) ||
      (ACC_W < PROD_W + clog2(TAPS))) begin : g_bad_params
    $error("fir2d_tap_accum: illegal TAPS/SHIFT/ACC_W combination");
  end

  localparam logic [TAP_IDX_W-1:0] LAST = TAP_IDX_W'(TAPS - 1);

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready
  // && !clr; a result transfers where out_valid && out_ready. in_ready never
  // depends on in_valid, and only the final tap of a window can stall.
  logic [TAP_IDX_W-1:0] tap_q, tap_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     sum_q, sum_d;
  logic [PIX_W-1:0]     pix_q, pix_d;
  logic                 ov_q, ov_d;

  logic                 accept;
  logic                 last_beat;
  logic                 out_take;
  logic [ACC_W-1:0]     acc_sum;
  logic [PIX_W-1:0]     pix_next;

  assign in_ready  = (tap_q != LAST) || !ov_q || out_ready;
  assign accept    = in_valid && in_ready && !clr;
  assign last_beat = accept && (tap_q == LAST);
  assign out_take  = ov_q && out_ready;
  assign acc_sum   = acc_q + {{(ACC_W - PROD_W){1'b0}}, ax};

  fir2d_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .sum (acc_sum),
    .pix (pix_next)
  );

  // The tap counter is the ACCUM state; tap_idx exposes it directly.
  always_comb begin
    tap_d = tap_q;
    acc_d = acc_q;
    sum_d = sum_q;
    pix_d = pix_q;
    ov_d  = ov_q;

    if (clr) begin
      tap_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (tap_q == LAST) begin
        tap_d = '0;
        acc_d = '0;
      end else begin
        tap_d = tap_q + 1'b1;
        acc_d = acc_sum;
      end
    end

    if (out_take) ov_d = 1'b0;
    // A completing window overrides the drain, so back-to-back results
    // keep out_valid high.
    if (last_beat) begin
      sum_d = acc_sum;
      pix_d = pix_next;
      ov_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      pix_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      tap_q <= tap_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      pix_q <= pix_d;
      ov_q  <= ov_d;
    end
  end

  assign tap_idx   = tap_q;
  assign sum_out   = sum_q;
  assign pix_out   = pix_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_fir2d_tap_accum.sv
// Directed and scoreboarded random checks for fir2d_tap_accum (TAPS=9, SHIFT=8).
module tb_fir2d_tap_accum;

  localparam int ACC_W = 20;
  localparam int NWIN  = 1000;

  logic              clk;
  logic              rst_n;
  logic [15:0]       ax;
  logic              in_valid;
  logic              in_ready;
  logic              clr;
  logic [3:0]        tap_idx;
  logic [ACC_W-1:0]  sum_out;
  logic [7:0]        pix_out;
  logic              out_valid;
  logic              out_ready;

  int checks   = 0;
  int failures = 0;

  logic [27:0] exp_q[$];

  fir2d_tap_accum #(.TAPS(9), .SHIFT(8), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ax        (ax),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .tap_idx   (tap_idx),
    .sum_out   (sum_out),
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [31:0] s);
    logic [31:0] r;
    r = (s + 32'd128) >> 8;
    return (r > 32'd255) ? 8'd255 : r[7:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1; in_ready is sampled at the negedge.
  task automatic send_beat(input logic [15:0] v);
    int n;
    in_valid = 1'b1;
    ax       = v;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    ax        = '0;
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_tap",       {28'd0, tap_idx}, 32'd0);
    chk("rst_sum",       {12'd0, sum_out}, 32'd0);
    chk("rst_pix",       {24'd0, pix_out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Window of 100s, tap_idx walks 0..8
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      ax       = 16'd100;
      @(negedge clk);
      chk("t1_tap_seq", {28'd0, tap_idx}, i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("t1_sum",   {12'd0, sum_out}, 32'd900);
    chk("t1_pix",   {24'd0, pix_out}, 32'd4);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_tap0",  {28'd0, tap_idx}, 32'd0);
    step();
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_sum_hold",   {12'd0, sum_out}, 32'd900);

    // Saturation and rounding edges
    repeat (9) send_beat(16'hFFFF);
    chk("t2_sum_max", {12'd0, sum_out}, 32'h8FFF7);
    chk("t2_pix_sat", {24'd0, pix_out}, 32'd255);
    repeat (9) send_beat(16'd127);
    chk("t2_sum_127", {12'd0, sum_out}, 32'd1143);
    chk("t2_pix_127", {24'd0, pix_out}, 32'd4);
    repeat (9) send_beat(16'd142);
    chk("t2_sum_142", {12'd0, sum_out}, 32'd1278);
    chk("t2_pix_142", {24'd0, pix_out}, 32'd5);
    step();
    chk("t2_drained", {31'd0, out_valid}, 32'd0);

    // Back-pressure: second window stalls only at its final tap
    out_ready = 1'b0;
    repeat (9) send_beat(16'd1);
    chk("t3_w1_sum",   {12'd0, sum_out}, 32'd9);
    chk("t3_w1_valid", {31'd0, out_valid}, 32'd1);
    repeat (8) send_beat(16'd2);
    chk("t3_tap8", {28'd0, tap_idx}, 32'd8);
    in_valid = 1'b1;
    ax       = 16'd2;
    @(negedge clk);
    chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_hold_sum",    {12'd0, sum_out}, 32'd9);
    step();
    @(negedge clk);
    chk("t3_stall_ready2", {31'd0, in_ready}, 32'd0);
    chk("t3_stall_tap",    {28'd0, tap_idx}, 32'd8);
    chk("t3_stall_valid",  {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("t3_w2_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_w2_sum",   {12'd0, sum_out}, 32'd18);
    chk("t3_w2_pix",   {24'd0, pix_out}, 32'd0);
    chk("t3_w2_tap0",  {28'd0, tap_idx}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("t3_drained",  {31'd0, out_valid}, 32'd0);
    chk("t3_sum_keep", {12'd0, sum_out}, 32'd18);

    // clr discards a partial window but leaves a pending result alone
    out_ready = 1'b0;
    repeat (9) send_beat(16'd7);
    repeat (4) send_beat(16'd50);
    chk("t4_tap4", {28'd0, tap_idx}, 32'd4);
    in_valid = 1'b1;
    ax       = 16'd999;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("t4_clr_tap",   {28'd0, tap_idx}, 32'd0);
    chk("t4_clr_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_clr_sum",   {12'd0, sum_out}, 32'd63);
    out_ready = 1'b1;
    repeat (9) send_beat(16'd10);
    chk("t4_sum", {12'd0, sum_out}, 32'd90);
    chk("t4_pix", {24'd0, pix_out}, 32'd0);
    chk("t4_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset mid-window with a pending result
    out_ready = 1'b0;
    repeat (5) send_beat(16'd20);
    chk("t5_tap5",  {28'd0, tap_idx}, 32'd5);
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_sum",   {12'd0, sum_out}, 32'd0);
    chk("t5_rst_pix",   {24'd0, pix_out}, 32'd0);
    chk("t5_rst_tap",   {28'd0, tap_idx}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random gaps and back-pressure, scoreboarded
    begin : rnd_phase
      bit mon_done;
      mon_done = 1'b0;
      fork
        begin : drv_in
          logic [15:0] v[9];
          logic [31:0] s;
          for (int w = 0; w < NWIN; w++) begin
            s = 0;
            for (int k = 0; k < 9; k++) begin
              v[k] = 16'($urandom_range(0, 65535));
              s    = s + {16'd0, v[k]};
            end
            exp_q.push_back({s[19:0], ref_pix(s)});
            for (int k = 0; k < 9; k++) begin
              repeat ($urandom_range(0, 1)) step();
              send_beat(v[k]);
            end
          end
        end
        begin : drv_out
          while (!mon_done) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
          out_ready = 1'b1;
        end
        begin : monitor
          int got;
          int cyc;
          logic [27:0] e;
          got = 0;
          cyc = 0;
          while (got < NWIN && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
              end else begin
                e = exp_q.pop_front();
                chk("sb_sum", {12'd0, sum_out}, {12'd0, e[27:8]});
                chk("sb_pix", {24'd0, pix_out}, {24'd0, e[7:0]});
              end
              got++;
            end
          end
          chk("sb_windows", got, NWIN);
          mon_done = 1'b1;
        end
      join
    end
    chk("sb_leftover", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
